// File: rtl/mem_slave_if.sv
// mem_slave_if: write/read bus between the bench driver and the memory slave
interface mem_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              wr_rd;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              addr_err;
    modport master (output data, addr, wr_rd, input data_out, rd_valid, addr_err);
    modport slave  (input data, addr, wr_rd, output data_out, rd_valid, addr_err);
endinterface

// File: rtl/mem_slave.sv
// mem_slave: flop-based word memory with registered read data, read strobe and range error flag
module mem_slave #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
    input logic         clk,
    input logic         rst,
    mem_slave_if.slave  bus
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              addr_err;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    assign in_range = bus.addr < ADDR_W'(DEPTH);
    assign idx      = bus.addr[IDX_W-1:0];
    assign bus.data_out = data_out;
    assign bus.rd_valid = rd_valid;
    assign bus.addr_err = addr_err;
    // One transaction per edge; reset clears the whole array so it must stay in flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            data_out <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= !in_range;
            rd_valid <= !bus.wr_rd;
            if (bus.wr_rd && in_range) mem[idx] <= bus.data;
            if (!bus.wr_rd) data_out <= in_range ? mem[idx] : ERR_DATA;
        end
    end
endmodule

// File: tb/tb_mem_slave.sv
// tb_mem_slave: scoreboard bench for mem_slave with a reference memory model
module tb_mem_slave;
    typedef struct packed {
        logic [31:0] dout;
        logic        valid;
        logic        err;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [16];
    logic [31:0] last_dout = '0;
    exp_t        sb [$];
    mem_slave_if #(.DATA_W(32), .ADDR_W(32)) bus ();
    mem_slave dut (.clk(clk), .rst(rst), .bus(bus.slave));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic model_clear();
        for (int i = 0; i < 16; i++) model[i] = '0;
        last_dout = '0;
    endtask
    task automatic cycle(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.err = a >= 32'd16;
        if (w) begin
            if (!e.err) model[a[3:0]] = d;
            e.valid = 1'b0;
        end else begin
            last_dout = e.err ? 32'hDEAD_BEEF : model[a[3:0]];
            e.valid = 1'b1;
        end
        e.dout = last_dout;
        sb.push_back(e);
        bus.wr_rd = w;
        bus.addr  = a;
        bus.data  = d;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".dout"}, bus.data_out, e.dout);
        chk({tag, ".valid"}, {31'd0, bus.rd_valid}, {31'd0, e.valid});
        chk({tag, ".err"}, {31'd0, bus.addr_err}, {31'd0, e.err});
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, ".dout"}, bus.data_out, 32'd0);
        chk({tag, ".valid"}, {31'd0, bus.rd_valid}, 32'd0);
        chk({tag, ".err"}, {31'd0, bus.addr_err}, 32'd0);
    endtask
    initial begin
        bus.wr_rd = 1'b0;
        bus.addr  = '0;
        bus.data  = '0;
        model_clear();
        #1 rst = 1'b1;
        #1 chk_zero("rst_async");
        repeat (3) @(posedge clk);
        #1 chk_zero("rst_hold");
        rst = 1'b0;
        for (int k = 0; k < 16; k++) cycle("rst_rd", 1'b0, k, '0);
        for (int k = 0; k < 16; k++) cycle("wr", 1'b1, k, 32'hA5A5_0000 + k);
        for (int k = 0; k < 16; k++) cycle("rd", 1'b0, k, '0);
        cycle("raw_wr", 1'b1, 32'd5, 32'h1234_5678);
        cycle("raw_rd", 1'b0, 32'd5, '0);
        cycle("oor_wr", 1'b1, 32'd16, 32'hFFFF_FFFF);
        cycle("oor_rd16", 1'b0, 32'd16, '0);
        cycle("oor_rdhi", 1'b0, 32'h8000_0000, '0);
        cycle("alias0", 1'b0, 32'd0, '0);
        cycle("hold_wr3", 1'b1, 32'd3, 32'h0000_0033);
        cycle("hold_rd3", 1'b0, 32'd3, '0);
        cycle("hold_w1", 1'b1, 32'd8, 32'h0BAD_0001);
        cycle("hold_w2", 1'b1, 32'd9, 32'h0BAD_0002);
        cycle("b2b_rd8", 1'b0, 32'd8, '0);
        cycle("b2b_rd9", 1'b0, 32'd9, '0);
        cycle("mid_wr7", 1'b1, 32'd7, 32'hCAFE_F00D);
        cycle("mid_rd7", 1'b0, 32'd7, '0);
        cycle("mid_rd16", 1'b0, 32'd16, '0);
        bus.wr_rd = 1'b0;
        bus.addr  = 32'd7;
        #2 rst = 1'b1;
        #1 chk_zero("mid_async");
        @(posedge clk);
        #1 chk_zero("mid_hold");
        rst = 1'b0;
        model_clear();
        cycle("post_rd7", 1'b0, 32'd7, '0);
        cycle("post_rd0", 1'b0, 32'd0, '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
